// File: rtl/prog_counter.sv
// Up/down programmable counter with a runtime terminal value, wrap or saturate
// behaviour, a clamped synchronous load and a one-cycle terminal-event pulse.
module prog_counter #(
  parameter int WIDTH     = 4,
  parameter int RESET_MAX = 9
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             DIR,
  input  logic             SAT,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic [WIDTH-1:0] MAX_VAL,
  output logic [WIDTH-1:0] COUNT,
  output logic             TRIG_OUT,
  output logic             AT_LIMIT
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  // RESET_MAX only records the MAX_VAL the system expects after reset.
  if (RESET_MAX < 0) begin : g_reset_max_doc
  end

  logic [WIDTH-1:0] count_q = '0;
  logic [WIDTH-1:0] count_d;
  logic             trig_q  = 1'b0;
  logic             trig_d;

  logic             at_up;
  logic             at_down;
  logic [WIDTH-1:0] load_clamped;

  // Terminal tests use the pre-step value, so no carry or borrow ever escapes.
  assign at_up        = (count_q >= MAX_VAL);
  assign at_down      = (count_q == '0);
  assign load_clamped = (LOAD_VAL > MAX_VAL) ? MAX_VAL : LOAD_VAL;

  always_comb begin
    count_d = count_q;
    trig_d  = 1'b0;
    if (RESET) begin
      count_d = '0;
    end else if (LOAD) begin
      count_d = load_clamped;
    end else if (ENABLE) begin
      if (DIR) begin
        if (at_up) begin
          count_d = SAT ? MAX_VAL : '0;
          trig_d  = ~SAT;
        end else begin
          count_d = count_q + One;
          trig_d  = SAT && ((count_q + One) == MAX_VAL);
        end
      end else begin
        if (at_down) begin
          count_d = SAT ? '0 : MAX_VAL;
          trig_d  = ~SAT;
        end else if (count_q > MAX_VAL) begin
          count_d = MAX_VAL;
        end else begin
          count_d = count_q - One;
          trig_d  = SAT && (count_q == One);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    count_q <= count_d;
    trig_q  <= trig_d;
  end

  assign COUNT    = count_q;
  assign TRIG_OUT = trig_q;
  assign AT_LIMIT = DIR ? at_up : at_down;

endmodule
